booth_step_counter: RTL and testbench
=====================================

// Module: booth_step_counter
// PURPOSE
//   Programmable iteration counter and terminal-count comparator for the Booth multiplier control path.
//   Generalises the fixed 4'hE cycle compare:
//   - parametrised width
//   - per-operation terminal count, latched at start
//   - start/busy/abort control
//   - one-cycle registered valid_out pulse when the final step has been counted
//   Sits between the multiplier FSM (start/abort) and the datapath/result register (valid_out).
// PARAMETERS
//   WIDTH       4    counter and terminal-count width in bits (>=2)
//   DEFAULT_TC  14   tc_q value after reset; tc_q is overwritten on every accepted start
// PORTS
//   clk             input   1      single clock, all flops rising-edge
//   reset           input   1      asynchronous, active-low reset (0 = reset asserted)
//   start           input   1      begin counting; sampled only in IDLE
//   abort           input   1      cancel current operation; no valid_out
//   terminal_count  input   WIDTH  last count value, latched into tc_q when start is accepted
//   count           output  WIDTH  current step index, registered
//   busy            output  1      high while state==RUN
//   last_step       output  1      combinational: busy && (count==tc_q)
//   valid_out       output  1      registered one-cycle pulse after the final step
// BEHAVIOUR
//   Reset (reset==0, asynchronous) values:
//   - state=IDLE, count=0, valid_out=0, busy=0, tc_q=DEFAULT_TC
//   - reset mid-RUN discards the operation immediately; no valid_out
//   FSM with 2 states, IDLE and RUN.
//   IDLE transitions:
//   - start=1, abort=0 -> RUN; count<=0; tc_q<=terminal_count
//   - start=1, abort=1 -> stays IDLE (abort wins)
//   RUN transitions:
//   - count!=tc_q -> count<=count+1
//   - count==tc_q -> IDLE; count<=0; valid_out<=1 for exactly one cycle
//   - abort=1 -> IDLE; count<=0; valid_out stays 0
//   - abort beats the terminal match in the same cycle
//   - start is ignored in RUN
//   Latency:
//   - start sampled at edge E0 -> count==k after edge Ek
//   - valid_out high in the cycle following edge E(tc+1)
//   - tc=14 gives valid_out during the cycle after the 15th edge following E0
//   - tc=0 gives one RUN cycle, valid_out after E1
//   Width rules:
//   - count never wraps, since compare precedes increment
//   - tc=2^WIDTH-1 is legal: maximum 2^WIDTH RUN cycles
//   - terminal_count changes during RUN have no effect (tc_q held)
//   valid_out is 0 in every cycle except the single pulse cycle.
// CONFIGURATION
//   BOOTH_STEP_CNT_AUTORELOAD_EN defined:
//   - start=1 on the terminal edge (count==tc_q, abort=0) -> stay in RUN
//   - count<=0, tc_q<=terminal_count, valid_out still pulses
//   - gives back-to-back operations with no IDLE gap
//   Not defined:
//   - start on the terminal edge is ignored
//   - one IDLE cycle is required before a new start is accepted
// STRUCTURE
//   booth_pkg holds:
//   - typedef enum logic {IDLE, RUN} step_state_t
//   - localparam BOOTH_CNT_WIDTH_DEFAULT=4
//   - localparam BOOTH_TC_DEFAULT=14
//   Single flat module; no sub-module (counter, compare and FSM are too tightly coupled to split).
// TESTING
//   1. Reset released; start=1 for 1 cycle, tc=14 -> busy for 15 cycles, count 0..14, single valid_out pulse, back to IDLE.
//   2. tc=0 and tc=2^WIDTH-1 (WIDTH=4: tc=15) -> 1 and 16 RUN cycles respectively; no count wrap; one pulse each.
//   3. abort at count=5, then abort coincident with count==tc -> IDLE, count=0, valid_out never asserted.
//   4. start re-pulsed at count=3 and terminal_count changed mid-RUN -> ignored; completes against original tc_q.
//   5. reset driven 0 asynchronously (between edges) at count=7 -> outputs clear immediately; next start counts from 0.
//   6. start held high, tc=3 -> AUTORELOAD_EN: pulse every 4 cycles, no IDLE; undefined: pulse every 5 cycles.

Source files
------------

// File: rtl/booth_pkg.sv
// Shared types and defaults for the Booth multiplier step counter.
//   step_state_t             : IDLE / RUN state encoding
//   BOOTH_CNT_WIDTH_DEFAULT  : default counter width in bits
//   BOOTH_TC_DEFAULT         : terminal count loaded at reset (classic 4'hE compare)
package booth_pkg;

    typedef enum logic {IDLE, RUN} step_state_t;

    localparam int BOOTH_CNT_WIDTH_DEFAULT = 4;
    localparam int BOOTH_TC_DEFAULT        = 14;

endpackage

// File: rtl/booth_step_counter_if.sv
// Control/status bundle between the multiplier FSM and the step counter.
//   master : multiplier FSM side, drives start/abort/terminal_count
//   slave  : step counter side, drives count/busy/last_step/valid_out
interface booth_step_counter_if
    import booth_pkg::*;
#(
    parameter int WIDTH = BOOTH_CNT_WIDTH_DEFAULT
);
    logic             start;
    logic             abort;
    logic [WIDTH-1:0] terminal_count;
    logic [WIDTH-1:0] count;
    logic             busy;
    logic             last_step;
    logic             valid_out;

    modport master (
        output start, abort, terminal_count,
        input  count, busy, last_step, valid_out
    );

    modport slave (
        input  start, abort, terminal_count,
        output count, busy, last_step, valid_out
    );
endinterface

// File: rtl/booth_step_counter.sv
// Programmable iteration counter and terminal-count comparator for the
// Booth multiplier control path.
//   clk   : rising-edge clock
//   reset : asynchronous, active-low
//   bus   : booth_step_counter_if.slave
//           start/abort/terminal_count in; count, busy, last_step (comb),
//           valid_out (registered one-cycle pulse) out
// Optional feature: BOOTH_STEP_CNT_AUTORELOAD_EN -- a start seen on the
// terminal edge reloads tc_q and keeps RUN, giving back-to-back operations.
module booth_step_counter
    import booth_pkg::*;
#(
    parameter int WIDTH      = BOOTH_CNT_WIDTH_DEFAULT,
    parameter int DEFAULT_TC = BOOTH_TC_DEFAULT
) (
    input  logic                clk,
    input  logic                reset,
    booth_step_counter_if.slave bus
);

    step_state_t      state_q;
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] tc_q;
    logic             valid_q;
    logic             term_hit;

    // Compare happens before increment, so count_q never reaches past tc_q
    // and cannot wrap even when tc_q is all ones.
    assign term_hit = (count_q == tc_q);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            count_q <= '0;
            tc_q    <= WIDTH'(DEFAULT_TC);
            valid_q <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start && !bus.abort) begin
                        state_q <= RUN;
                        count_q <= '0;
                        tc_q    <= bus.terminal_count;
                    end
                end
                RUN: begin
                    // abort takes priority over a coincident terminal match
                    if (bus.abort) begin
                        state_q <= IDLE;
                        count_q <= '0;
                    end else if (term_hit) begin
                        count_q <= '0;
                        valid_q <= 1'b1;
`ifdef BOOTH_STEP_CNT_AUTORELOAD_EN
                        if (bus.start) begin
                            tc_q <= bus.terminal_count;
                        end else begin
                            state_q <= IDLE;
                        end
`else
                        state_q <= IDLE;
`endif
                    end else begin
                        count_q <= count_q + WIDTH'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    count_q <= '0;
                end
            endcase
        end
    end

    assign bus.count     = count_q;
    assign bus.busy      = (state_q == RUN);
    assign bus.last_step = (state_q == RUN) && term_hit;
    assign bus.valid_out = valid_q;

endmodule

// File: tb/tb_booth_step_counter.sv
// Directed self-checking bench for booth_step_counter (WIDTH=4).
// Honours BOOTH_STEP_CNT_AUTORELOAD_EN for the held-start scenario.
module tb_booth_step_counter;
    import booth_pkg::*;

    localparam int W = 4;

    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;

    booth_step_counter_if #(.WIDTH(W)) bus ();

    booth_step_counter #(.WIDTH(W), .DEFAULT_TC(14)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Start an operation with the given tc and follow it to completion.
    task automatic run_check(input int tc, input string tag);
        int k;
        bus.start          = 1'b1;
        bus.terminal_count = W'(tc);
        step();
        bus.start = 1'b0;
        k = 0;
        while (bus.busy && k < 40) begin
            chk({tag, "_count"}, int'(bus.count), k);
            chk({tag, "_vld_low"}, int'(bus.valid_out), 0);
            chk({tag, "_last"}, int'(bus.last_step), (k == tc) ? 1 : 0);
            step();
            k++;
        end
        chk({tag, "_cycles"}, k, tc + 1);
        chk({tag, "_pulse"}, int'(bus.valid_out), 1);
        chk({tag, "_cnt0"}, int'(bus.count), 0);
        step();
        chk({tag, "_pulse_end"}, int'(bus.valid_out), 0);
        chk({tag, "_idle"}, int'(bus.busy), 0);
    endtask

    initial begin
        int k;
        int p [3];
        int np;
`ifdef BOOTH_STEP_CNT_AUTORELOAD_EN
        int period = 4;
        int pulse_busy = 1;
`else
        int period = 5;
        int pulse_busy = 0;
`endif
        n_tests = 0;
        n_fail  = 0;
        reset              = 1'b0;
        bus.start          = 1'b0;
        bus.abort          = 1'b0;
        bus.terminal_count = '0;

        // reset state
        #12;
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_count", int'(bus.count), 0);
        chk("rst_valid", int'(bus.valid_out), 0);
        chk("rst_last", int'(bus.last_step), 0);
        reset = 1'b1;
        step();
        step();
        chk("idle_valid", int'(bus.valid_out), 0);

        // 1: default-style 15-cycle operation
        run_check(14, "tc14");
        // 2: boundary terminal counts
        run_check(0, "tc0");
        run_check(15, "tc15");

        // start with abort in IDLE: abort wins
        bus.start = 1'b1;
        bus.abort = 1'b1;
        bus.terminal_count = 4'd5;
        step();
        bus.start = 1'b0;
        bus.abort = 1'b0;
        chk("idle_abort_busy", int'(bus.busy), 0);

        // 3a: abort at count=5
        bus.start = 1'b1;
        bus.terminal_count = 4'd10;
        step();
        bus.start = 1'b0;
        for (int i = 0; i < 5; i++) step();
        chk("ab5_count", int'(bus.count), 5);
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        chk("ab5_busy", int'(bus.busy), 0);
        chk("ab5_count0", int'(bus.count), 0);
        chk("ab5_valid", int'(bus.valid_out), 0);
        step();
        chk("ab5_valid2", int'(bus.valid_out), 0);

        // 3b: abort coincident with terminal match
        bus.start = 1'b1;
        bus.terminal_count = 4'd2;
        step();
        bus.start = 1'b0;
        step();
        step();
        chk("abtc_last", int'(bus.last_step), 1);
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        chk("abtc_busy", int'(bus.busy), 0);
        chk("abtc_valid", int'(bus.valid_out), 0);
        step();
        chk("abtc_valid2", int'(bus.valid_out), 0);

        // 4: restart and tc change mid-RUN are ignored
        bus.start = 1'b1;
        bus.terminal_count = 4'd6;
        step();
        bus.start = 1'b0;
        for (int i = 0; i < 3; i++) step();
        chk("ign_count3", int'(bus.count), 3);
        bus.start = 1'b1;
        bus.terminal_count = 4'd2;
        step();
        bus.start = 1'b0;
        chk("ign_count4", int'(bus.count), 4);
        k = 4;
        while (bus.busy && k < 40) begin
            chk("ign_vld_low", int'(bus.valid_out), 0);
            step();
            k++;
        end
        chk("ign_cycles", k, 7);
        chk("ign_pulse", int'(bus.valid_out), 1);
        step();

        // 5: asynchronous reset between edges at count=7
        bus.start = 1'b1;
        bus.terminal_count = 4'd14;
        step();
        bus.start = 1'b0;
        for (int i = 0; i < 7; i++) step();
        chk("arst_pre", int'(bus.count), 7);
        #2;
        reset = 1'b0;
        #1;
        chk("arst_count", int'(bus.count), 0);
        chk("arst_busy", int'(bus.busy), 0);
        chk("arst_valid", int'(bus.valid_out), 0);
        reset = 1'b1;
        step();
        chk("arst_after", int'(bus.valid_out), 0);
        run_check(3, "post_rst");

        // 6: start held high, tc=3
        bus.start = 1'b1;
        bus.terminal_count = 4'd3;
        step();
        np = 0;
        p = '{-100, -50, 0};
        for (int c = 1; c <= 30 && np < 3; c++) begin
            step();
            if (bus.valid_out) begin
                if (np == 0) chk("held_pulse_busy", int'(bus.busy), pulse_busy);
                p[np] = c;
                np++;
            end
        end
        chk("held_npulses", np, 3);
        chk("held_gap1", p[1] - p[0], period);
        chk("held_gap2", p[2] - p[1], period);
        bus.start = 1'b0;
        k = 0;
        while (bus.busy && k < 40) begin
            step();
            k++;
        end
        chk("held_drain", int'(bus.busy), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
